// File: rtl/pipelined_cla_adder_if.sv
// Streaming operand/result bundle for the pipelined CLA adder.
// Master drives operands and out_ready; slave returns results.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor, GROUP_W-bit CLA groups,
// PIPE_GROUPS groups per stage, group carry registered between stages.
module pipelined_cla_adder #(
    parameter int WIDTH       = 16,
    parameter int GROUP_W     = 4,
    parameter int PIPE_GROUPS = 1
) (
    input logic                   clk,
    input logic                   rst,
    pipelined_cla_adder_if.slave  bus
);
    localparam int NG  = WIDTH / GROUP_W;
    localparam int LAT = NG / PIPE_GROUPS;

    // Rank 0 holds captured operands; rank k+1 holds the output of stage k.
    // Later-group operand bits ride along (skew), finished sum bits accumulate
    // in r_s so a whole word leaves the last rank together (de-skew).
    logic [WIDTH-1:0] r_a [0:LAT];
    logic [WIDTH-1:0] r_b [0:LAT];
    logic [WIDTH-1:0] r_s [0:LAT];
    logic [LAT:0]     r_c;
    logic [LAT:0]     r_v;
    logic             r_ovf;

    logic [WIDTH-1:0] w_s [0:LAT-1];
    logic [LAT-1:0]   w_c;
    logic [LAT-1:0]   w_m;
    logic             w_stall;

    // One CLA group, every carry expanded as a sum of products.
    // Returns {carry out, carry into MSB, sum}.
    function automatic logic [GROUP_W+1:0] cla_group(
        input logic [GROUP_W-1:0] a,
        input logic [GROUP_W-1:0] b,
        input logic               c0
    );
        logic [GROUP_W-1:0] g;
        logic [GROUP_W-1:0] p;
        logic [GROUP_W:0]   c;
        logic               t;
        logic               pp;
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        for (int i = 0; i < GROUP_W; i++) begin
            t = c0;
            for (int j = 0; j <= i; j++) begin
                t = t & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                pp = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    pp = pp & p[k];
                end
                t = t | pp;
            end
            c[i+1] = t;
        end
        return {c[GROUP_W], c[GROUP_W-1], p ^ c[GROUP_W-1:0]};
    endfunction

    assign w_stall      = r_v[LAT] & ~bus.out_ready;
    assign bus.in_ready = ~w_stall;
    assign bus.out_valid = r_v[LAT];
    assign bus.sum      = r_s[LAT];
    assign bus.cout     = r_c[LAT];
    assign bus.ovf      = r_ovf;

    // Each stage resolves its groups from the carry left by the previous stage.
    always_comb begin : p_stages
        logic [GROUP_W+1:0] w_res;
        int                 idx;
        w_res = '0;
        idx   = 0;
        for (int k = 0; k < LAT; k++) begin
            w_s[k] = r_s[k];
            w_c[k] = r_c[k];
            w_m[k] = 1'b0;
            for (int g = 0; g < PIPE_GROUPS; g++) begin
                idx   = k * PIPE_GROUPS + g;
                w_res = cla_group(r_a[k][idx*GROUP_W +: GROUP_W],
                                  r_b[k][idx*GROUP_W +: GROUP_W],
                                  w_c[k]);
                w_s[k][idx*GROUP_W +: GROUP_W] = w_res[GROUP_W-1:0];
                w_m[k] = w_res[GROUP_W];
                w_c[k] = w_res[GROUP_W+1];
            end
        end
    end

    // Pipeline ranks: all advance together unless the output is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k <= LAT; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else if (!w_stall) begin
            r_v[0] <= bus.in_valid;
            if (bus.in_valid) begin
                r_a[0] <= bus.a;
                r_b[0] <= bus.sub ? ~bus.b : bus.b;
                r_c[0] <= bus.sub | bus.cin;
                r_s[0] <= '0;
            end
            for (int k = 0; k < LAT; k++) begin
                r_v[k+1] <= r_v[k];
                if (r_v[k]) begin
                    r_a[k+1] <= r_a[k];
                    r_b[k+1] <= r_b[k];
                    r_s[k+1] <= w_s[k];
                    r_c[k+1] <= w_c[k];
                end
            end
            if (r_v[LAT-1]) begin
                r_ovf <= w_c[LAT-1] ^ w_m[LAT-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and model-checked bench for pipelined_cla_adder,
// default config plus PIPE_GROUPS=2 and WIDTH=32/GROUP_W=8 variants.
module tb_pipelined_cla_adder;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    pipelined_cla_adder_if #(.WIDTH(16)) bus ();
    pipelined_cla_adder_if #(.WIDTH(16)) bus2 ();
    pipelined_cla_adder_if #(.WIDTH(32)) bus3 ();

    pipelined_cla_adder #(.WIDTH(16), .GROUP_W(4), .PIPE_GROUPS(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    pipelined_cla_adder #(.WIDTH(16), .GROUP_W(4), .PIPE_GROUPS(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    pipelined_cla_adder #(.WIDTH(32), .GROUP_W(8), .PIPE_GROUPS(1)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: {cout, ovf, sum} in a 34-bit word.
    function automatic logic [33:0] ref_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic cin,
                                              input logic sub,
                                              input int w);
        logic [63:0] mask;
        logic [63:0] bb;
        logic [63:0] t;
        logic        c0;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        bb   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
        c0   = sub ? 1'b1 : cin;
        t    = {32'd0, a} + bb + {63'd0, c0};
        ov   = (a[w-1] == bb[w-1]) && (t[w-1] != a[w-1]);
        return {t[w], ov, t[31:0] & mask[31:0]};
    endfunction

    // Send one vector on the default DUT and check exact latency of 4.
    task automatic run_one(input string tag, input logic [15:0] a,
                           input logic [15:0] b, input logic cin,
                           input logic sub, input logic [15:0] es,
                           input logic ec, input logic eo);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.sub      = sub;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk({tag, "_early"}, {63'd0, bus.out_valid}, 64'd0);
        tick();
        chk(tag, {45'd0, bus.out_valid, bus.cout, bus.ovf, bus.sum},
            {45'd0, 1'b1, ec, eo, es});
        tick();
        chk({tag, "_once"}, {63'd0, bus.out_valid}, 64'd0);
    endtask

    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic        vc [8];
    logic [33:0] q [$];
    logic [33:0] e2 [1000];
    logic [33:0] e3 [1000];
    logic [33:0] ex;
    int          sent;
    int          got;
    int          seen;

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        {bus.in_valid, bus.a, bus.b, bus.cin, bus.sub} = '0;
        {bus2.in_valid, bus2.a, bus2.b, bus2.cin, bus2.sub} = '0;
        {bus3.in_valid, bus3.a, bus3.b, bus3.cin, bus3.sub} = '0;
        bus.out_ready  = 1'b1;
        bus2.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;

        chk("rst_state", {44'd0, bus.in_ready, bus.out_valid, bus.cout,
            bus.ovf, bus.sum}, {44'd0, 1'b1, 19'd0});

        run_one("zero",      16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        run_one("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_one("sub_cin",   16'h0003, 16'h0003, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_one("cin_in",    16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            va[i] = 16'($urandom);
            vb[i] = 16'($urandom);
            vc[i] = 1'($urandom);
        end
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            if (sent < 8) begin
                bus.in_valid = 1'b1;
                bus.a        = va[sent];
                bus.b        = vb[sent];
                bus.cin      = vc[sent];
                bus.sub      = 1'b0;
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = !(cyc >= 5 && cyc <= 7);
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                chk("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_extra", {63'd0, bus.out_valid}, 64'd0);
                end else begin
                    ex = q.pop_front();
                    chk("stream", {46'd0, bus.cout, bus.ovf, bus.sum},
                        {46'd0, ex[33:32], ex[15:0]});
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_model({16'd0, va[sent]}, {16'd0, vb[sent]},
                                      vc[sent], 1'b0, 16));
                sent++;
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stream_got", 64'(got), 64'd8);
        chk("stream_sent", 64'(sent), 64'd8);

        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'h1234 + 16'(i);
            bus.b        = 16'h1111;
            bus.cin      = 1'b0;
            bus.sub      = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_flush_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_flush_sum", {48'd0, bus.sum}, 64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        chk("rst_flush_none", 64'(seen), 64'd0);

        for (int j = 0; j < 1002; j++) begin
            if (j < 1000) begin
                bus2.a   = (j % 16 == 0) ? 16'hFFFF : 16'($urandom);
                bus2.b   = 16'($urandom);
                bus2.cin = 1'($urandom);
                bus2.sub = 1'($urandom);
                e2[j]    = ref_model({16'd0, bus2.a}, {16'd0, bus2.b},
                                     bus2.cin, bus2.sub, 16);
                bus2.in_valid = 1'b1;
            end else begin
                bus2.in_valid = 1'b0;
            end
            tick();
            if (j >= 2) begin
                chk("pg2", {45'd0, bus2.out_valid, bus2.cout, bus2.ovf,
                    bus2.sum}, {45'd0, 1'b1, e2[j-2][33:32], e2[j-2][15:0]});
            end
        end

        for (int j = 0; j < 1004; j++) begin
            if (j < 1000) begin
                bus3.a   = (j % 16 == 0) ? 32'hFFFF_FFFF : $urandom;
                bus3.b   = $urandom;
                bus3.cin = 1'($urandom);
                bus3.sub = 1'($urandom);
                e3[j]    = ref_model(bus3.a, bus3.b, bus3.cin, bus3.sub, 32);
                bus3.in_valid = 1'b1;
            end else begin
                bus3.in_valid = 1'b0;
            end
            tick();
            if (j >= 4) begin
                chk("w32", {29'd0, bus3.out_valid, bus3.cout, bus3.ovf,
                    bus3.sum}, {29'd0, 1'b1, e3[j-4]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
